// File: rtl/lr_expand.sv
// Expands one compressed check-to-variable word into six signed per-edge
// messages, emitted serially one edge per cycle over a valid/ready stream.
module lr_expand #(
  parameter int D_WID   = 8,
  parameter int CNT_WID = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lr_valid,
  output logic                 lr_ready,
  input  logic [2*D_WID+9:0]   lr_in,
  input  logic                 lr_zero,
  output logic                 msg_valid,
  input  logic                 msg_ready,
  output logic [D_WID-1:0]     msg_out,
  output logic [2:0]           msg_idx,
  output logic                 msg_last,
  output logic [CNT_WID-1:0]   word_cnt,
  output logic                 loc_err,
  input  logic                 err_clr
);

  localparam int W = 2*D_WID+10;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t             state_r, state_n;
  logic [2:0]         idx_r, idx_n;
  logic [W-1:0]       hold_r, hold_n;
  logic               zero_r, zero_n;
  logic               capture_s, cnt_inc_s, ready_s;
  logic               msg_valid_r, msg_last_r, loc_err_r;
  logic [D_WID-1:0]   msg_out_r;
  logic [2:0]         msg_idx_r;
  logic [CNT_WID-1:0] word_cnt_r;

  // Edge k takes the second minimum only at the least location; an out-of-range
  // location (6/7) never matches, so every edge then takes the least magnitude.
  function automatic logic [D_WID-1:0] expand_edge(input logic [W-1:0] w,
                                                   input logic       z,
                                                   input logic [2:0] k);
    logic [D_WID-1:0] mag;
    logic [D_WID-1:0] lim;
    logic [5:0]       s;
    logic             neg;
    s   = w[5:0];
    mag = (w[9:7] == k) ? w[D_WID+9:10] : w[2*D_WID+9:D_WID+10];
    lim = mag[D_WID-1] ? {1'b0, {(D_WID-1){1'b1}}} : mag;
    neg = s[3'd5 - k] ^ w[6];
    return z ? {D_WID{1'b0}}
             : (neg ? (~lim + {{(D_WID-1){1'b0}}, 1'b1}) : lim);
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_n;
  end

  // Next-state, edge index and handshake decode
  always_comb begin
    state_n   = state_r;
    idx_n     = idx_r;
    capture_s = 1'b0;
    cnt_inc_s = 1'b0;
    ready_s   = 1'b0;
    case (state_r)
      IDLE: begin
        ready_s = 1'b1;
        if (lr_valid) begin
          capture_s = 1'b1;
          idx_n     = 3'd0;
          state_n   = SEND;
        end else begin
          state_n   = IDLE;
        end
      end
      SEND: begin
        if (msg_ready) begin
          if (idx_r == 3'd5) begin
            ready_s   = 1'b1;
            cnt_inc_s = 1'b1;
            if (lr_valid) begin
              capture_s = 1'b1;
              idx_n     = 3'd0;
            end else begin
              state_n   = IDLE;
            end
          end else begin
            idx_n = idx_r + 3'd1;
          end
        end else begin
          idx_n = idx_r;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign lr_ready = ready_s & ~reset;
  assign hold_n   = capture_s ? lr_in   : hold_r;
  assign zero_n   = capture_s ? lr_zero : zero_r;

  // Hold register, registered message outputs, counter and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_r      <= {W{1'b0}};
      zero_r      <= 1'b0;
      idx_r       <= 3'd0;
      msg_valid_r <= 1'b0;
      msg_out_r   <= {D_WID{1'b0}};
      msg_idx_r   <= 3'd0;
      msg_last_r  <= 1'b0;
      word_cnt_r  <= {CNT_WID{1'b0}};
      loc_err_r   <= 1'b0;
    end else begin
      hold_r      <= hold_n;
      zero_r      <= zero_n;
      idx_r       <= idx_n;
      msg_valid_r <= (state_n == SEND);
      msg_idx_r   <= idx_n;
      msg_last_r  <= (state_n == SEND) && (idx_n == 3'd5);
      msg_out_r   <= (state_n == SEND) ? expand_edge(hold_n, zero_n, idx_n)
                                       : {D_WID{1'b0}};
      word_cnt_r  <= word_cnt_r + {{(CNT_WID-1){1'b0}}, cnt_inc_s};
      if (capture_s && (lr_in[9:7] > 3'd5)) begin
        loc_err_r <= 1'b1;
      end else if (err_clr) begin
        loc_err_r <= 1'b0;
      end else begin
        loc_err_r <= loc_err_r;
      end
    end
  end

  assign msg_valid = msg_valid_r;
  assign msg_out   = msg_out_r;
  assign msg_idx   = msg_idx_r;
  assign msg_last  = msg_last_r;
  assign word_cnt  = word_cnt_r;
  assign loc_err   = loc_err_r;

endmodule

// File: tb/tb_lr_expand.sv
// Self-checking bench for lr_expand: directed scenarios plus random traffic,
// scored against a queue-based model of the expected edge messages.
module tb_lr_expand;

  logic        clk = 1'b0;
  logic        reset, lr_valid, lr_ready, lr_zero;
  logic [25:0] lr_in;
  logic        msg_valid, msg_ready, msg_last, loc_err, err_clr;
  logic [7:0]  msg_out;
  logic [2:0]  msg_idx;
  logic [15:0] word_cnt;

  lr_expand #(.D_WID(8), .CNT_WID(16)) dut (
    .clk(clk), .reset(reset), .lr_valid(lr_valid), .lr_ready(lr_ready),
    .lr_in(lr_in), .lr_zero(lr_zero), .msg_valid(msg_valid),
    .msg_ready(msg_ready), .msg_out(msg_out), .msg_idx(msg_idx),
    .msg_last(msg_last), .word_cnt(word_cnt), .loc_err(loc_err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] v; int idx; } msg_t;
  msg_t       exp_q[$];
  logic [7:0] obs_q[$];
  int         m_cnt = 0;
  logic       m_err = 1'b0;
  int         errors = 0;
  int         checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Edge value straight from the rules, in integer arithmetic
  function automatic logic [7:0] ref_edge(input logic [25:0] w, input logic z,
                                          input int k);
    int least, less, loc, mag, v;
    logic neg;
    least = int'(w[25:18]);
    less  = int'(w[17:10]);
    loc   = int'(w[9:7]);
    mag   = (loc == k) ? less : least;
    if (mag > 127) mag = 127;
    neg = w[5-k] ^ w[6];
    v   = neg ? -mag : mag;
    if (z) v = 0;
    return v[7:0];
  endfunction

  // One clock: drive at the falling edge, check, then update the model
  task automatic tick(input logic rs, input logic lv, input logic [25:0] w,
                      input logic z, input logic mr, input logic ec);
    logic rdy;
    msg_t m;
    reset = rs; lr_valid = lv; lr_in = w; lr_zero = z;
    msg_ready = mr; err_clr = ec;
    #1;
    rdy = !rs && ((exp_q.size() == 0) || (exp_q.size() == 1 && mr));
    check_eq("lr_ready", {31'd0, lr_ready}, {31'd0, rdy});
    check_eq("msg_valid", {31'd0, msg_valid}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      check_eq("msg_out", {24'd0, msg_out}, {24'd0, exp_q[0].v});
      check_eq("msg_idx", {29'd0, msg_idx}, exp_q[0].idx);
      check_eq("msg_last", {31'd0, msg_last}, {31'd0, exp_q[0].idx == 5});
    end
    check_eq("word_cnt", {16'd0, word_cnt}, m_cnt);
    check_eq("loc_err", {31'd0, loc_err}, {31'd0, m_err});
    @(posedge clk);
    if (rs) begin
      exp_q.delete();
      m_cnt = 0;
      m_err = 1'b0;
    end else begin
      if (exp_q.size() != 0 && mr) begin
        m = exp_q.pop_front();
        obs_q.push_back(msg_out);
        if (m.idx == 5) m_cnt = (m_cnt + 1) % 65536;
      end
      if (lv && rdy) begin
        for (int k = 0; k < 6; k++) begin
          m.v = ref_edge(w, z, k);
          m.idx = k;
          exp_q.push_back(m);
        end
      end
      if (lv && rdy && w[9:7] > 3'd5) m_err = 1'b1;
      else if (ec) m_err = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle_ticks(input int n, input logic mr);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 26'd0, 1'b0, mr, 1'b0);
  endtask

  logic [25:0] w1, w2, w3, wr;
  logic [7:0]  seq1 [6];

  initial begin
    reset = 1'b1; lr_valid = 1'b0; lr_in = 26'd0; lr_zero = 1'b0;
    msg_ready = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    tick(1'b1, 1'b0, 26'd0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 26'h3ffffff, 1'b0, 1'b1, 1'b0);
    check_eq("rst_out", {24'd0, msg_out}, 32'd0);
    check_eq("rst_idx", {29'd0, msg_idx}, 32'd0);
    check_eq("rst_last", {31'd0, msg_last}, 32'd0);

    // Reset in the middle of a word: edges 0..2 accepted, then dropped
    w1 = {8'h05, 8'h09, 3'd2, 1'b1, 6'b100000};
    tick(1'b0, 1'b1, w1, 1'b0, 1'b1, 1'b0);
    idle_ticks(3, 1'b1);
    tick(1'b1, 1'b0, 26'd0, 1'b0, 1'b1, 1'b0);
    idle_ticks(2, 1'b1);

    // Sign and location mapping
    obs_q.delete();
    tick(1'b0, 1'b1, w1, 1'b0, 1'b1, 1'b0);
    idle_ticks(7, 1'b1);
    seq1 = '{8'h05, 8'hFB, 8'hF7, 8'hFB, 8'hFB, 8'hFB};
    check_eq("map_len", obs_q.size(), 32'd6);
    for (int i = 0; i < 6 && i < obs_q.size(); i++)
      check_eq("map_val", {24'd0, obs_q[i]}, {24'd0, seq1[i]});
    check_eq("map_cnt", {16'd0, word_cnt}, 32'd1);

    // Clamp of both least and less magnitudes
    obs_q.delete();
    w2 = {8'h80, 8'h80, 3'd0, 1'b0, 6'b010000};
    tick(1'b0, 1'b1, w2, 1'b0, 1'b1, 1'b0);
    idle_ticks(7, 1'b1);
    check_eq("clamp_e0", {24'd0, obs_q[0]}, 32'h7F);
    check_eq("clamp_e1", {24'd0, obs_q[1]}, 32'h81);

    // Back-to-back words with lr_valid held high
    w2 = {8'h11, 8'h22, 3'd4, 1'b0, 6'b001011};
    w3 = {8'h7E, 8'h03, 3'd1, 1'b1, 6'b110101};
    tick(1'b0, 1'b1, w2, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, w3, 1'b0, 1'b1, 1'b0);
    idle_ticks(7, 1'b1);
    check_eq("b2b_cnt", {16'd0, word_cnt}, 32'd4);

    // Backpressure at edge 3
    tick(1'b0, 1'b1, w3, 1'b0, 1'b1, 1'b0);
    idle_ticks(3, 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, w2, 1'b0, 1'b0, 1'b0);
    check_eq("stall_idx", {29'd0, msg_idx}, 32'd3);
    idle_ticks(4, 1'b1);

    // Out-of-range location, sticky error, clear; then a zero word
    obs_q.delete();
    wr = {8'h20, 8'h10, 3'd7, 1'b0, 6'b000000};
    tick(1'b0, 1'b1, wr, 1'b0, 1'b1, 1'b0);
    idle_ticks(8, 1'b1);
    check_eq("loc7_e2", {24'd0, obs_q[2]}, 32'h20);
    check_eq("loc_err_set", {31'd0, loc_err}, 32'd1);
    tick(1'b0, 1'b0, 26'd0, 1'b0, 1'b1, 1'b1);
    check_eq("loc_err_clr", {31'd0, loc_err}, 32'd0);
    obs_q.delete();
    tick(1'b0, 1'b1, 26'h3A5C3F1, 1'b1, 1'b1, 1'b0);
    idle_ticks(7, 1'b1);
    check_eq("zero_e4", {24'd0, obs_q[4]}, 32'd0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      wr = 26'($urandom);
      tick($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, wr,
           $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0);
    end
    idle_ticks(10, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
